// File: rtl/strait_sa_pkg.sv
// Shared types and sizing helpers for the STRAIT weight-stationary systolic array.
// The state encoding is fixed because the test controller decodes it.
package strait_sa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } sa_state_e;

  // Accept edge to aligned result: skew + grid traversal + deskew + output register.
  function automatic int sa_latency(input int rows, input int cols);
    return rows + cols;
  endfunction

  function automatic int psum_width(input int ww, input int aw, input int rows);
    return ww + aw + $clog2(rows);
  endfunction

endpackage

// File: rtl/sa_pe_ws.sv
// One weight-stationary processing element: stationary weight, registered
// activation pass-through and a registered MAC that can be bypassed.
module sa_pe_ws
  import strait_sa_pkg::*;
#(
  parameter int WW  = 8,
  parameter int AW  = 8,
  parameter int PSW = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           w_load,
  input  logic [WW-1:0]  w_in,
  input  logic           pe_off,
  input  logic [AW-1:0]  act_in,
  input  logic [PSW-1:0] psum_in,
  output logic [AW-1:0]  act_out,
  output logic [PSW-1:0] psum_out
);

  logic [WW-1:0]    w_q, w_d;
  logic [AW-1:0]    act_q, act_d;
  logic [PSW-1:0]   psum_q, psum_d;
  logic [WW+AW-1:0] prod;

  assign prod = act_in * w_q;

  // A disabled PE still spends one register on the psum so column timing is unchanged.
  always_comb begin
    w_d    = w_load ? w_in : w_q;
    act_d  = act_in;
    psum_d = pe_off ? psum_in : psum_in + PSW'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      act_q  <= '0;
      psum_q <= '0;
    end else begin
      w_q    <= w_d;
      act_q  <= act_d;
      psum_q <= psum_d;
    end
  end

  assign act_out  = act_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/systolic_array_ws.sv
// ROWS x COLS weight-stationary systolic array with weight-load sequencing,
// input skew, output deskew and a valid pipe that tracks accepted vectors.
module systolic_array_ws
  import strait_sa_pkg::*;
#(
  parameter int ROWS              = 8,
  parameter int COLS              = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, ROWS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              reuse_w,
  input  logic [ROWS*COLS-1:0]              pe_disable,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [COLS*WEIGHT_WIDTH-1:0]      w_row_flat,
  input  logic                              act_valid,
  output logic                              act_ready,
  input  logic                              act_last,
  input  logic [ROWS*ACTIVATION_WIDTH-1:0]  act_flat,
  output logic                              out_valid,
  output logic [COLS*PARTIAL_SUM_WIDTH-1:0] out_flat,
  output logic                              busy,
  output logic                              done
);

  localparam int WW  = WEIGHT_WIDTH;
  localparam int AW  = ACTIVATION_WIDTH;
  localparam int PSW = PARTIAL_SUM_WIDTH;
  localparam int LAT = sa_latency(ROWS, COLS);
  localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  sa_state_e         state_q, state_d;
  logic [CW-1:0]     row_cnt_q, row_cnt_d;
  logic              done_q, done_d;
  logic [LAT-1:0]    valid_pipe_q, valid_pipe_d;
  logic              out_valid_q, out_valid_d;
  logic [COLS*PSW-1:0] out_flat_q, out_flat_d;

  logic              w_fire;
  logic              act_fire;
  logic              pipe_drained;
  logic [ROWS-1:0]   w_load;

  logic [AW-1:0]     act_h  [ROWS][COLS+1];
  logic [PSW-1:0]    psum_v [ROWS+1][COLS];
  logic [PSW-1:0]    col_res [COLS];

  assign w_ready   = (state_q == LOAD);
  assign act_ready = (state_q == COMPUTE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_flat  = out_flat_q;

  assign w_fire   = w_valid & w_ready;
  assign act_fire = act_valid & act_ready;

  // DRAIN may leave once nothing but the oldest vector remains: it lands in
  // the output register on the same edge the FSM returns to IDLE.
  assign pipe_drained = (valid_pipe_q[LAT-2:0] == '0);

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_cnt_d = '0;
          state_d   = reuse_w ? COMPUTE : LOAD;
        end
      end
      LOAD: begin
        if (w_fire) begin
          if (row_cnt_q == CW'(ROWS - 1)) begin
            row_cnt_d = '0;
            state_d   = COMPUTE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (act_fire && act_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_drained) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    valid_pipe_d = {valid_pipe_q[LAT-2:0], act_fire};
    out_valid_d  = valid_pipe_q[LAT-1];
    out_flat_d   = out_flat_q;
    if (valid_pipe_q[LAT-1]) begin
      for (int c = 0; c < COLS; c++) out_flat_d[c*PSW +: PSW] = col_res[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe_q <= '0;
      out_valid_q  <= 1'b0;
      out_flat_q   <= '0;
    end else begin
      valid_pipe_q <= valid_pipe_d;
      out_valid_q  <= out_valid_d;
      out_flat_q   <= out_flat_d;
    end
  end

  // Row r gets r+1 registers: a common capture stage plus r cycles of skew.
  // Bubble cycles inject zeros so idle PEs add nothing.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [AW-1:0] sk_q [r+1];
    logic [AW-1:0] sk_d [r+1];

    always_comb begin
      sk_d[0] = act_fire ? act_flat[r*AW +: AW] : '0;
      for (int k = 1; k <= r; k++) sk_d[k] = sk_q[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) sk_q[k] <= '0;
      end else begin
        sk_q <= sk_d;
      end
    end

    assign act_h[r][0] = sk_q[r];
    assign w_load[r]   = w_fire && (row_cnt_q == CW'(r));
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top
    assign psum_v[0][c] = '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe_ws #(
        .WW  (WW),
        .AW  (AW),
        .PSW (PSW)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .w_load   (w_load[r]),
        .w_in     (w_row_flat[c*WW +: WW]),
        .pe_off   (pe_disable[r*COLS + c]),
        .act_in   (act_h[r][c]),
        .psum_in  (psum_v[r][c]),
        .act_out  (act_h[r][c+1]),
        .psum_out (psum_v[r+1][c])
      );
    end
  end

  // Column c finishes c cycles after column 0; delay it COLS-1-c to realign.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_none
      assign col_res[c] = psum_v[ROWS][c];
    end else begin : g_dly
      logic [PSW-1:0] ds_q [D];
      logic [PSW-1:0] ds_d [D];

      always_comb begin
        ds_d[0] = psum_v[ROWS][c];
        for (int k = 1; k < D; k++) ds_d[k] = ds_q[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) ds_q[k] <= '0;
        end else begin
          ds_q <= ds_d;
        end
      end

      assign col_res[c] = ds_q[D-1];
    end
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Self-checking bench: a 4x3 array driven from a vector table with a latency-aware
// scoreboard, plus a default 8x8 array for the full-width accumulation case.
module tb_systolic_array_ws;

  localparam int R    = 4;
  localparam int C    = 3;
  localparam int PSW  = 18;
  localparam int LAT  = 7;
  localparam int BR   = 8;
  localparam int BC   = 8;
  localparam int BPSW = 19;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;

  logic             start, reuse_w, w_valid, act_valid, act_last;
  logic [R*C-1:0]   pe_disable;
  logic [C*8-1:0]   w_row_flat;
  logic [R*8-1:0]   act_flat;
  logic             w_ready, act_ready, out_valid, busy, done;
  logic [C*PSW-1:0] out_flat;

  logic               b_start, b_reuse_w, b_w_valid, b_act_valid, b_act_last;
  logic [BR*BC-1:0]   b_pe_disable;
  logic [BC*8-1:0]    b_w_row_flat;
  logic [BR*8-1:0]    b_act_flat;
  logic               b_w_ready, b_act_ready, b_out_valid, b_busy, b_done;
  logic [BC*BPSW-1:0] b_out_flat;

  systolic_array_ws #(
    .ROWS(R), .COLS(C), .WEIGHT_WIDTH(8), .ACTIVATION_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w), .pe_disable(pe_disable),
    .w_valid(w_valid), .w_ready(w_ready), .w_row_flat(w_row_flat),
    .act_valid(act_valid), .act_ready(act_ready), .act_last(act_last), .act_flat(act_flat),
    .out_valid(out_valid), .out_flat(out_flat), .busy(busy), .done(done)
  );

  systolic_array_ws dut_big (
    .clk(clk), .rst(rst), .start(b_start), .reuse_w(b_reuse_w), .pe_disable(b_pe_disable),
    .w_valid(b_w_valid), .w_ready(b_w_ready), .w_row_flat(b_w_row_flat),
    .act_valid(b_act_valid), .act_ready(b_act_ready), .act_last(b_act_last), .act_flat(b_act_flat),
    .out_valid(b_out_valid), .out_flat(b_out_flat), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               grp;
    logic [R*8-1:0]   act;
    logic             valid;
    logic             last;
    logic [C*PSW-1:0] expv;
  } vec_t;

  typedef struct {
    logic [C*PSW-1:0] expv;
    int               due;
  } sb_t;

  vec_t tab[$];
  sb_t  sb[$];
  sb_t  monE;
  int   lastAcc;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Scoreboard consumer: every out_valid must match the oldest pending vector, on time.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_out_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        monE = sb.pop_front();
        checkOutput("result_latency", 64'(cyc), 64'(monE.due));
        for (int c = 0; c < C; c++)
          checkOutput($sformatf("result_col%0d", c), 64'(out_flat[c*PSW +: PSW]),
                      64'(monE.expv[c*PSW +: PSW]));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    act_valid = v.valid;
    act_flat  = v.act;
    act_last  = v.last;
    if (v.valid && act_ready) begin
      sb.push_back('{expv: v.expv, due: cyc + 1 + LAT});
      lastAcc = cyc + 1;
    end
    @(negedge clk);
    act_valid = 1'b0;
    act_last  = 1'b0;
    act_flat  = '0;
  endtask

  task automatic runGroup(input int g);
    foreach (tab[i]) if (tab[i].grp == g) applyStimulus(tab[i]);
  endtask

  task automatic startJob(input logic reuse);
    start   = 1'b1;
    reuse_w = reuse;
    @(negedge clk);
    start   = 1'b0;
    reuse_w = 1'b0;
  endtask

  task automatic loadWeights(input logic [R*C*8-1:0] wAll);
    for (int k = 0; k < R; k++) begin
      w_valid    = 1'b1;
      w_row_flat = wAll[k*C*8 +: C*8];
      @(negedge clk);
    end
    w_valid    = 1'b0;
    w_row_flat = '0;
  endtask

  task automatic waitDone(output int dc);
    dc = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("done_seen", 64'(dc >= 0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  dc;
    int  accB;
    int  seen;
    logic sawDone;

    tab.push_back('{grp: 1, act: {8'd8, 8'd7, 8'd6, 8'd5}, valid: 1'b1, last: 1'b1,
                    expv: {18'd7, 18'd6, 18'd5}});
    tab.push_back('{grp: 2, act: {8'd1, 8'd1, 8'd1, 8'd1}, valid: 1'b1, last: 1'b0,
                    expv: {18'd8, 18'd8, 18'd8}});
    tab.push_back('{grp: 2, act: '0, valid: 1'b0, last: 1'b0, expv: '0});
    tab.push_back('{grp: 2, act: {8'd4, 8'd0, 8'd0, 8'd3}, valid: 1'b1, last: 1'b1,
                    expv: {18'd14, 18'd14, 18'd14}});
    tab.push_back('{grp: 3, act: {8'd4, 8'd3, 8'd2, 8'd1}, valid: 1'b1, last: 1'b1,
                    expv: {18'd10, 18'd8, 18'd10}});
    tab.push_back('{grp: 4, act: {8'd4, 8'd3, 8'd2, 8'd1}, valid: 1'b1, last: 1'b1,
                    expv: {18'd10, 18'd10, 18'd10}});
    tab.push_back('{grp: 5, act: {8'd1, 8'd1, 8'd1, 8'd1}, valid: 1'b1, last: 1'b0,
                    expv: {18'd4, 18'd4, 18'd4}});
    tab.push_back('{grp: 5, act: {8'd2, 8'd2, 8'd2, 8'd2}, valid: 1'b1, last: 1'b0,
                    expv: {18'd8, 18'd8, 18'd8}});
    tab.push_back('{grp: 5, act: {8'd3, 8'd3, 8'd3, 8'd3}, valid: 1'b1, last: 1'b1,
                    expv: {18'd12, 18'd12, 18'd12}});

    rst = 1'b1;
    start = 0; reuse_w = 0; w_valid = 0; act_valid = 0; act_last = 0;
    pe_disable = '0; w_row_flat = '0; act_flat = '0;
    b_start = 0; b_reuse_w = 0; b_w_valid = 0; b_act_valid = 0; b_act_last = 0;
    b_pe_disable = '0; b_w_row_flat = '0; b_act_flat = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset_out_valid", 64'(out_valid), 0);
    checkOutput("reset_busy", 64'(busy), 0);
    checkOutput("reset_done", 64'(done), 0);
    checkOutput("reset_w_ready", 64'(w_ready), 0);
    checkOutput("reset_act_ready", 64'(act_ready), 0);
    checkOutput("reset_out_flat", 64'(out_flat), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] identity weights");
    startJob(1'b0);
    checkOutput("load_w_ready", 64'(w_ready), 1);
    loadWeights({24'h000000, 24'h010000, 24'h000100, 24'h000001});
    checkOutput("compute_act_ready", 64'(act_ready), 1);
    runGroup(1);
    checkOutput("busy_in_drain", 64'(busy), 1);
    waitDone(dc);
    checkOutput("identity_done_latency", 64'(dc - lastAcc), 64'(LAT));
    checkOutput("busy_drops_with_done", 64'(busy), 0);
    repeat (3) @(negedge clk);
    checkOutput("hold_out_valid_low", 64'(out_valid), 0);
    checkOutput("hold_out_flat_col1", 64'(out_flat[PSW +: PSW]), 6);

    $display("[TB] stream with bubble");
    startJob(1'b0);
    loadWeights({12{8'd2}});
    runGroup(2);
    waitDone(dc);

    $display("[TB] PE disable");
    pe_disable = 12'(1 << (1*C + 1));
    startJob(1'b0);
    loadWeights({12{8'd1}});
    runGroup(3);
    waitDone(dc);
    @(negedge clk);
    pe_disable = '0;

    $display("[TB] weight reuse and ignored controls");
    startJob(1'b1);
    checkOutput("reuse_skips_load", 64'(w_ready), 0);
    checkOutput("reuse_in_compute", 64'(act_ready), 1);
    start      = 1'b1;
    w_valid    = 1'b1;
    w_row_flat = '1;
    repeat (2) @(negedge clk);
    start      = 1'b0;
    w_valid    = 1'b0;
    w_row_flat = '0;
    checkOutput("start_ignored_in_compute", 64'(act_ready), 1);
    checkOutput("w_ready_low_in_compute", 64'(w_ready), 0);
    runGroup(4);
    waitDone(dc);

    $display("[TB] reset during drain");
    startJob(1'b1);
    runGroup(5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 0);
    checkOutput("midreset_done", 64'(done), 0);
    checkOutput("midreset_busy", 64'(busy), 0);
    checkOutput("midreset_act_ready", 64'(act_ready), 0);
    checkOutput("midreset_out_flat", 64'(out_flat), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("no_done_after_reset", 64'(sawDone), 0);
    checkOutput("idle_after_reset", 64'(busy), 0);

    $display("[TB] full-width 8x8 accumulation");
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    checkOutput("big_w_ready", 64'(b_w_ready), 1);
    for (int k = 0; k < BR; k++) begin
      b_w_valid    = 1'b1;
      b_w_row_flat = '1;
      @(negedge clk);
    end
    b_w_valid = 1'b0;
    checkOutput("big_act_ready", 64'(b_act_ready), 1);
    b_act_valid = 1'b1;
    b_act_flat  = '1;
    b_act_last  = 1'b1;
    accB = cyc + 1;
    @(negedge clk);
    b_act_valid = 1'b0;
    b_act_last  = 1'b0;
    checkOutput("big_busy", 64'(b_busy), 1);
    seen = -1;
    for (int i = 0; i < 60; i++) begin
      if (b_out_valid) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("big_latency", 64'(seen - accB), 16);
    for (int c = 0; c < BC; c++)
      checkOutput($sformatf("big_col%0d", c), 64'(b_out_flat[c*BPSW +: BPSW]), 520200);
    checkOutput("big_done_with_result", 64'(b_done), 1);

    @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
